// File: rtl/bsg_mem_1rw_sync_rr_ctrl.sv
// Round-robin controller sharing one synchronous 1RW RAM among num_ports_p requesters.
// Commands use a valid/yumi handshake; read data returns through a one-entry response register per port.
module bsg_mem_1rw_sync_rr_ctrl #(
  parameter int unsigned num_ports_p = 2,
  parameter int unsigned width_p     = 32,
  parameter int unsigned els_p       = 256,
  localparam int unsigned addr_width_lp = $clog2(els_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_ports_p-1:0]                 v_i,
  input  logic [num_ports_p-1:0]                 w_i,
  input  logic [num_ports_p*addr_width_lp-1:0]   addr_i,
  input  logic [num_ports_p*width_p-1:0]         data_i,
  output logic [num_ports_p-1:0]                 yumi_o,
  output logic [num_ports_p-1:0]                 resp_v_o,
  output logic [num_ports_p*width_p-1:0]         resp_data_o,
  input  logic [num_ports_p-1:0]                 resp_yumi_i,
  output logic                                   mem_v_o,
  output logic                                   mem_w_o,
  output logic [addr_width_lp-1:0]               mem_addr_o,
  output logic [width_p-1:0]                     mem_data_o,
  input  logic [width_p-1:0]                     mem_data_i
);

  localparam int unsigned ptr_width_lp = $clog2(num_ports_p);

  logic [ptr_width_lp-1:0]               r_last;
  logic [ptr_width_lp-1:0]               r_rd_port;
  logic                                  r_rd_inflight;
  logic [num_ports_p-1:0]                r_resp_v;
  logic [num_ports_p-1:0][width_p-1:0]   r_resp_data;

  logic [num_ports_p-1:0]                w_read_ok;
  logic [num_ports_p-1:0]                w_elig;
  logic [num_ports_p-1:0]                w_capture;
  logic [ptr_width_lp-1:0]               w_cand;
  logic [ptr_width_lp-1:0]               w_gnt_idx;
  logic                                  w_found;
  logic                                  w_gnt_v;

  // A read may issue only if nothing is in flight for the port and its response slot frees up.
  always_comb begin
    w_read_ok = '0;
    w_elig    = '0;
    w_capture = '0;
    for (int unsigned p = 0; p < num_ports_p; p++) begin
      w_capture[p] = r_rd_inflight & (r_rd_port == ptr_width_lp'(p));
      w_read_ok[p] = ~w_capture[p] & (~r_resp_v[p] | resp_yumi_i[p]);
      w_elig[p]    = v_i[p] & (w_i[p] | w_read_ok[p]);
    end
  end

  // Round-robin search starting one past the last winner.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int unsigned k = 1; k <= num_ports_p; k++) begin
      w_cand = ptr_width_lp'((32'(r_last) + k) % num_ports_p);
      if (!w_found && w_elig[w_cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign w_gnt_v     = w_found & reset_n_i;
  assign yumi_o      = w_gnt_v ? (num_ports_p'(1) << w_gnt_idx) : '0;
  assign mem_v_o     = w_gnt_v;
  assign mem_w_o     = w_gnt_v & w_i[w_gnt_idx];
  assign mem_addr_o  = w_gnt_v ? addr_i[32'(w_gnt_idx)*addr_width_lp +: addr_width_lp] : '0;
  assign mem_data_o  = (w_gnt_v & w_i[w_gnt_idx]) ? data_i[32'(w_gnt_idx)*width_p +: width_p] : '0;
  assign resp_v_o    = r_resp_v;
  assign resp_data_o = r_resp_data;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_last        <= ptr_width_lp'(num_ports_p - 1);
      r_rd_inflight <= 1'b0;
      r_rd_port     <= '0;
      r_resp_v      <= '0;
      r_resp_data   <= '0;
    end else begin
      if (w_gnt_v) begin
        r_last    <= w_gnt_idx;
        r_rd_port <= w_gnt_idx;
      end
      r_rd_inflight <= w_gnt_v & ~w_i[w_gnt_idx];
      // A capture wins over a same-edge consume so fresh data is never dropped.
      r_resp_v      <= w_capture | (r_resp_v & ~resp_yumi_i);
      for (int unsigned p = 0; p < num_ports_p; p++) begin
        if (w_capture[p]) r_resp_data[p] <= mem_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert ($onehot0(yumi_o)) else $error("yumi_o is not one-hot-or-zero");
      assert ((resp_yumi_i & ~r_resp_v) == '0) else $error("resp_yumi_i without resp_v_o");
    end
  end

  // Out-of-range addresses only exist when the depth is not a power of two.
  if ((2 ** addr_width_lp) != els_p) begin : g_addr_chk
    always_ff @(posedge clk_i) begin
      if (reset_n_i && w_gnt_v) begin
        assert (32'(mem_addr_o) < els_p) else $error("accepted address out of range");
      end
    end
  end

endmodule

// File: tb/tb_bsg_mem_1rw_sync_rr_ctrl.sv
// Bench for bsg_mem_1rw_sync_rr_ctrl: directed handshake/arbitration cases, then random 4-port
// traffic against a RAM model, with per-port read-data scoreboards.
module tb_bsg_mem_1rw_sync_rr_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned E  = 256;
  localparam int unsigned AW = 8;

  logic             clk = 1'b0;
  logic             reset_n_i;
  logic [N-1:0]     v_i, w_i, yumi_o, resp_v_o, resp_yumi_i;
  logic [N*AW-1:0]  addr_i;
  logic [N*W-1:0]   data_i, resp_data_o;
  logic             mem_v_o, mem_w_o;
  logic [AW-1:0]    mem_addr_o;
  logic [W-1:0]     mem_data_o, mem_data_i;

  logic [N-1:0]     cons_en;
  logic [W-1:0]     ram [E];
  logic [W-1:0]     mdl [E];
  logic [W-1:0]     sbq [N][$];
  int               n_chk = 0;
  int               n_fail = 0;

  always #5 clk = ~clk;

  bsg_mem_1rw_sync_rr_ctrl #(.num_ports_p(N), .width_p(W), .els_p(E)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .w_i(w_i), .addr_i(addr_i), .data_i(data_i),
    .yumi_o(yumi_o), .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i)
  );

  // Synchronous 1RW RAM, read data valid the cycle after the access.
  always @(posedge clk) begin
    if (mem_v_o) begin
      if (mem_w_o) ram[mem_addr_o] <= mem_data_o;
      else         mem_data_i      <= ram[mem_addr_o];
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cmd(input int p, input bit v, input bit w, input int a, input logic [W-1:0] d);
    v_i[p]            = v;
    w_i[p]            = w;
    addr_i[p*AW +: AW] = AW'(a);
    data_i[p*W +: W]   = d;
  endtask

  // Drive the consumer, let logic settle, then update the model and scoreboard.
  task automatic settle();
    resp_yumi_i = cons_en & resp_v_o;
    #2;
    for (int p = 0; p < int'(N); p++) begin
      if (yumi_o[p]) begin
        if (w_i[p]) mdl[addr_i[p*AW +: AW]] = data_i[p*W +: W];
        else        sbq[p].push_back(mdl[addr_i[p*AW +: AW]]);
      end
      if (resp_v_o[p] && resp_yumi_i[p]) begin
        if (sbq[p].size() == 0) chk($sformatf("sb_unexpected_p%0d", p), 64'(resp_data_o[p*W +: W]), 64'hdead);
        else chk($sformatf("rd_data_p%0d", p), 64'(resp_data_o[p*W +: W]), 64'(sbq[p].pop_front()));
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    v_i = '0; w_i = '0; addr_i = '0; data_i = '0; resp_yumi_i = '0; cons_en = '0;
    for (int p = 0; p < int'(N); p++) sbq[p].delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n_i = 1'b1;
  endtask

  int           wcnt [N];
  bit           pend [N];
  int           alist [4] = '{10, 11, 20, 5};
  logic [N-1:0] exp_y;

  initial begin
    do_reset();

    // 1: write then read the same address on port 0.
    settle(); chk("rst_resp_v", 64'(resp_v_o), 0); chk("rst_yumi", 64'(yumi_o), 0);
    chk("idle_mem_v", 64'(mem_v_o), 0); chk("idle_mem_addr", 64'(mem_addr_o), 0); adv();
    cmd(0, 1, 1, 5, 32'hAB); settle();
    chk("t1_wr_yumi", 64'(yumi_o), 64'h1); chk("t1_mem_w", 64'(mem_w_o), 1);
    chk("t1_mem_addr", 64'(mem_addr_o), 5); chk("t1_mem_data", 64'(mem_data_o), 64'hAB); adv();
    cmd(0, 1, 0, 5, 0); cons_en = 4'b0001; settle();
    chk("t1_rd_yumi", 64'(yumi_o), 64'h1); chk("t1_rd_mem_w", 64'(mem_w_o), 0); adv();
    cmd(0, 0, 0, 0, 0); settle(); chk("t1_resp_t1", 64'(resp_v_o), 0); adv();
    settle(); chk("t1_resp_t2", 64'(resp_v_o), 64'h1);
    chk("t1_resp_data", 64'(resp_data_o[W-1:0]), 64'hAB); adv();
    settle(); chk("t1_resp_clr", 64'(resp_v_o), 0); adv();

    // 2: two ports holding writes alternate starting from port 0.
    do_reset();
    cmd(0, 1, 1, 10, 32'h1111_0000); cmd(1, 1, 1, 11, 32'h2222_0001);
    for (int i = 0; i < 6; i++) begin
      settle(); chk($sformatf("t2_grant%0d", i), 64'(yumi_o), (i % 2 == 0) ? 64'h1 : 64'h2); adv();
    end
    cmd(0, 0, 0, 0, 0); cmd(1, 0, 0, 0, 0);

    // 3: stalled port-1 response blocks port-1 reads only.
    cons_en = '0;
    cmd(1, 1, 0, 5, 0); settle(); chk("t3_rd_grant", 64'(yumi_o), 64'h2); adv();
    cmd(0, 1, 1, 20, 32'h55);
    for (int i = 0; i < 5; i++) begin
      settle(); chk($sformatf("t3_wr_only%0d", i), 64'(yumi_o), 64'h1);
      if (i >= 1) begin
        chk($sformatf("t3_hold_v%0d", i), 64'(resp_v_o[1]), 1);
        chk($sformatf("t3_hold_d%0d", i), 64'(resp_data_o[W +: W]), 64'hAB);
      end
      adv();
    end
    cmd(0, 0, 0, 0, 0); cmd(1, 0, 0, 0, 0); cons_en = 4'b0010;
    settle(); adv();
    settle(); chk("t3_resp_clr", 64'(resp_v_o), 0); adv();

    // 4: back-to-back reads on one port issue every second cycle.
    cons_en = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      cmd(0, 1, 0, alist[i/2], 0); settle();
      chk($sformatf("t4_grant%0d", i), 64'(yumi_o), (i % 2 == 0) ? 64'h1 : 64'h0); adv();
    end
    cmd(0, 0, 0, 0, 0);
    repeat (3) begin settle(); adv(); end

    // 5: reset right after a read grant discards it and restores port-0 priority.
    cons_en = 4'b1111;
    cmd(0, 1, 0, 5, 0); settle(); chk("t5_rd_grant", 64'(yumi_o), 64'h1); adv();
    reset_n_i = 1'b0; cmd(1, 1, 1, 30, 32'h77);
    settle(); chk("t5_rst_yumi", 64'(yumi_o), 0); chk("t5_rst_resp", 64'(resp_v_o), 0); adv();
    reset_n_i = 1'b1; sbq[0].delete();
    cmd(0, 1, 1, 31, 32'h66); settle();
    chk("t5_first_grant", 64'(yumi_o), 64'h1); chk("t5_resp_a", 64'(resp_v_o), 0); adv();
    cmd(0, 0, 0, 0, 0); cmd(1, 0, 0, 0, 0);
    settle(); chk("t5_resp_b", 64'(resp_v_o), 0); adv();
    settle(); chk("t5_resp_c", 64'(resp_v_o), 0); adv();

    // 6: random 4-port traffic over a preloaded address window.
    for (int a = 0; a < 16; a++) begin
      cmd(0, 1, 1, a, $urandom); settle(); adv();
    end
    cmd(0, 0, 0, 0, 0);
    for (int p = 0; p < int'(N); p++) begin wcnt[p] = 0; pend[p] = 0; end
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < int'(N); p++) begin
        if (!pend[p]) begin
          if ($urandom_range(9) < 6) begin
            cmd(p, 1, 1'($urandom_range(1)), $urandom_range(15), $urandom);
            pend[p] = 1;
          end else begin
            v_i[p] = 1'b0;
          end
        end
        cons_en[p] = ($urandom_range(9) < 7);
      end
      exp_y = v_i;
      settle();
      chk("t6_onehot", 64'($onehot0(yumi_o)), 1);
      chk("t6_grant_subset", 64'(yumi_o & ~exp_y), 0);
      for (int p = 0; p < int'(N); p++) begin
        if (v_i[p] && w_i[p] && !yumi_o[p]) wcnt[p]++;
        else wcnt[p] = 0;
        if (wcnt[p] > int'(N) - 1) chk($sformatf("t6_starve_p%0d", p), 64'(wcnt[p]), 64'(N - 1));
        if (yumi_o[p]) pend[p] = 0;
      end
      adv();
    end
    v_i = '0; cons_en = '1;
    repeat (6) begin settle(); adv(); end
    for (int p = 0; p < int'(N); p++) chk($sformatf("sb_empty_p%0d", p), 64'(sbq[p].size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
